// File: rtl/bus_guard_wb8.sv
// bus_guard_wb8: Wishbone watchdog that aborts CPU accesses left unacknowledged for TIMEOUT cycles
// and records the first fault, an overflow flag and a fault count in a register window with an interrupt.
module bus_guard_wb8 #(
   parameter int unsigned TIMEOUT = 255,
   parameter logic [7:0]  ERRDATA = 8'hFF
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic        M_STB_I,
   input  logic        M_WE_I,
   input  logic [31:0] M_ADR_I,
   output logic [7:0]  M_DAT_O,
   output logic        M_ACK_O,
   output logic        M_STALL_O,
   output logic        S_STB_O,
   input  logic [7:0]  S_DAT_I,
   input  logic        S_ACK_I,
   input  logic        S_STALL_I,
   input  logic        STB_I,
   input  logic        WE_I,
   input  logic [2:0]  ADR_I,
   input  logic [7:0]  DAT_I,
   output logic [7:0]  DAT_O,
   output logic        ACK_O,
   output logic        O_interrupt
);
   typedef enum logic [1:0] {IDLE, WAIT, ABORT} state_t;
   localparam logic [15:0] LAST = 16'(TIMEOUT - 1);
   state_t      state, state_nx;
   logic [15:0] cnt, cnt_nx;
   logic        abort, hit, wr, flag, ovf, fwe, ien, flag_w, ovf_w;
   logic [31:0] faddr;
   logic [7:0]  fcnt, fcnt_w, rd;

   always_ff @(posedge CLK_I or negedge RST_I)
      if (!RST_I) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end

   // The cycle that raises M_STB_I counts as the first, so the abort lands exactly TIMEOUT cycles in.
   always_comb begin
      state_nx = state;
      cnt_nx   = '0;
      case (state)
         IDLE:
            if (M_STB_I && !S_ACK_I) begin
               state_nx = WAIT;
               cnt_nx   = 16'd1;
            end
         WAIT:
            if (S_ACK_I || !M_STB_I) state_nx = IDLE;
            else if (cnt == LAST) state_nx = ABORT;
            else cnt_nx = cnt + 16'd1;
         default: state_nx = IDLE;
      endcase
   end

   assign abort     = state == ABORT;
   assign S_STB_O   = M_STB_I & ~abort;
   assign M_ACK_O   = S_ACK_I | abort;
   assign M_DAT_O   = abort ? ERRDATA : S_DAT_I;
   assign M_STALL_O = S_STALL_I & ~abort;

   assign hit = STB_I & ~ACK_O;
   assign wr  = hit & WE_I;
   // Clear writes are applied before the fault record, so a fault on the same edge always wins.
   assign flag_w = flag & ~(wr && ADR_I == 3'd0 && DAT_I[0]);
   assign ovf_w  = ovf & ~(wr && ADR_I == 3'd0 && DAT_I[7]);
   assign fcnt_w = (wr && ADR_I == 3'd5) ? 8'd0 : fcnt;

   always_comb begin
      rd = 8'd0;
      case (ADR_I)
         3'd0:    rd = {ovf, 5'd0, fwe, flag};
         3'd1:    rd = faddr[7:0];
         3'd2:    rd = faddr[15:8];
         3'd3:    rd = faddr[23:16];
         3'd4:    rd = faddr[31:24];
         3'd5:    rd = fcnt;
         3'd6:    rd = {7'd0, ien};
         default: rd = 8'd0;
      endcase
   end

   always_ff @(posedge CLK_I or negedge RST_I)
      if (!RST_I) begin
         ACK_O       <= 1'b0;
         DAT_O       <= 8'd0;
         ien         <= 1'b0;
         flag        <= 1'b0;
         ovf         <= 1'b0;
         fwe         <= 1'b0;
         faddr       <= 32'd0;
         fcnt        <= 8'd0;
         O_interrupt <= 1'b0;
      end else begin
         ACK_O <= hit;
         DAT_O <= hit ? rd : 8'd0;
         if (wr && ADR_I == 3'd6) ien <= DAT_I[0];
         flag <= flag_w | abort;
         ovf  <= ovf_w | (abort & flag_w);
         if (abort && !flag_w) begin
            faddr <= M_ADR_I;
            fwe   <= M_WE_I;
         end
         fcnt        <= (abort && fcnt_w != 8'hFF) ? fcnt_w + 8'd1 : fcnt_w;
         O_interrupt <= flag & ien;
      end
endmodule

// File: tb/tb_bus_guard_wb8.sv
// tb_bus_guard_wb8: vector table, directed corner sequences and random traffic checked
// against an access-age reference model of the watchdog and its register window.
module tb_bus_guard_wb8;
   localparam int TO = 8;
   localparam logic [7:0] ERR = 8'hFF;

   logic clk = 1'b0, rst_n = 1'b0;
   logic m_stb = 0, m_we = 0, s_ack = 0, s_stall = 0, stb = 0, we = 0;
   logic [31:0] m_adr = 0;
   logic [7:0] s_dat = 0, dat = 0;
   logic [2:0] adr = 0;
   logic [7:0] m_dat_o, dat_o;
   logic m_ack_o, m_stall_o, s_stb_o, ack_o, irq_o;

   bus_guard_wb8 #(.TIMEOUT(TO), .ERRDATA(ERR)) dut (
      .CLK_I(clk), .RST_I(rst_n), .M_STB_I(m_stb), .M_WE_I(m_we), .M_ADR_I(m_adr),
      .M_DAT_O(m_dat_o), .M_ACK_O(m_ack_o), .M_STALL_O(m_stall_o), .S_STB_O(s_stb_o),
      .S_DAT_I(s_dat), .S_ACK_I(s_ack), .S_STALL_I(s_stall), .STB_I(stb), .WE_I(we),
      .ADR_I(adr), .DAT_I(dat), .DAT_O(dat_o), .ACK_O(ack_o), .O_interrupt(irq_o));

   always #5 clk = ~clk;

   int checks = 0, passes = 0;
   int pend;
   logic x_flag, x_ovf, x_fwe, x_ien, x_irq, x_ack, e_mack_g;
   logic [31:0] x_faddr;
   logic [7:0] x_fcnt, x_dat;
   logic s_mack, s_sstb, s_irq;
   logic [7:0] s_mdat;

   typedef struct {
      logic stb, ack, stall;
      logic [7:0] d;
      logic e_stb, e_ack, e_stall;
      logic [7:0] e_d;
   } vec_t;
   vec_t tbl[8];

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
      else passes++;
   endtask

   task automatic mreset();
      pend = 0; x_flag = 0; x_ovf = 0; x_fwe = 0; x_ien = 0; x_irq = 0;
      x_ack = 0; x_faddr = 0; x_fcnt = 0; x_dat = 0;
   endtask

   function automatic logic [7:0] mread(input logic [2:0] a);
      case (a)
         3'd0: return {x_ovf, 5'd0, x_fwe, x_flag};
         3'd1: return x_faddr[7:0];
         3'd2: return x_faddr[15:8];
         3'd3: return x_faddr[23:16];
         3'd4: return x_faddr[31:24];
         3'd5: return x_fcnt;
         3'd6: return {7'd0, x_ien};
         default: return 8'd0;
      endcase
   endfunction

   // One bus cycle: inputs were driven 1 time unit after the edge; check at the falling edge.
   task automatic tick();
      logic ab, hit, nirq;
      logic [7:0] rd;
      #4;
      if (!rst_n) mreset();
      ab = (pend == TO);
      chk("s_stb_o", s_stb_o, ab ? 1'b0 : m_stb);
      chk("m_ack_o", m_ack_o, ab ? 1'b1 : s_ack);
      chk("m_dat_o", m_dat_o, ab ? ERR : s_dat);
      chk("m_stall_o", m_stall_o, ab ? 1'b0 : s_stall);
      chk("ack_o", ack_o, x_ack);
      chk("dat_o", dat_o, x_dat);
      chk("o_interrupt", irq_o, x_irq);
      s_mack = m_ack_o; s_mdat = m_dat_o; s_sstb = s_stb_o; s_irq = irq_o;
      e_mack_g = ab | s_ack;
      if (!rst_n) mreset();
      else begin
         hit = stb && !x_ack;
         rd = mread(adr);
         nirq = x_flag & x_ien;
         if (hit && we) begin
            if (adr == 3'd0) begin
               if (dat[0]) x_flag = 0;
               if (dat[7]) x_ovf = 0;
            end
            if (adr == 3'd5) x_fcnt = 0;
            if (adr == 3'd6) x_ien = dat[0];
         end
         if (ab) begin
            if (x_flag) x_ovf = 1;
            else begin x_flag = 1; x_faddr = m_adr; x_fwe = m_we; end
            if (x_fcnt != 8'hFF) x_fcnt++;
         end
         pend = ab ? 0 : (m_stb && !s_ack) ? pend + 1 : 0;
         x_ack = hit; x_dat = hit ? rd : 8'd0; x_irq = nirq;
      end
      @(posedge clk); #1;
   endtask

   task automatic rd_reg(input logic [2:0] a, output logic [7:0] v);
      stb = 1; we = 0; adr = a; tick();
      v = dat_o;
      stb = 0; tick();
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
      stb = 1; we = 1; adr = a; dat = d; tick();
      stb = 0; we = 0; tick();
   endtask

   task automatic access(input logic [31:0] a, input logic w, input int ack_at, input logic [7:0] d_in,
                         input int wr_at, input logic [2:0] wa, input logic [7:0] wd,
                         output int ack_cyc, output int n_ack, output logic [7:0] d,
                         output int irq_cyc, output int irq_low);
      ack_cyc = -1; n_ack = 0; d = 0; irq_cyc = -1; irq_low = 0;
      m_adr = a; m_we = w; m_stb = 1; s_dat = d_in;
      for (int c = 0; c < TO + 4; c++) begin
         s_ack = (c == ack_at);
         stb = (c == wr_at); we = stb; adr = wa; dat = wd;
         tick();
         if (s_mack) begin
            if (ack_cyc < 0) begin ack_cyc = c; d = s_mdat; end
            n_ack++;
            m_stb = 0;
         end
         if (s_irq && irq_cyc < 0) irq_cyc = c;
         if (!s_irq) irq_low++;
      end
      s_ack = 0; stb = 0; we = 0; m_stb = 0;
   endtask

   initial begin
      logic [7:0] v, d;
      int ac, na, ic, il, hi, ak;
      tbl[0] = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00};
      tbl[1] = '{1, 0, 1, 8'hA5, 1, 0, 1, 8'hA5};
      tbl[2] = '{1, 0, 0, 8'h3C, 1, 0, 0, 8'h3C};
      tbl[3] = '{1, 1, 0, 8'hC3, 1, 1, 0, 8'hC3};
      tbl[4] = '{0, 1, 1, 8'hFF, 0, 1, 1, 8'hFF};
      tbl[5] = '{1, 1, 1, 8'h00, 1, 1, 1, 8'h00};
      tbl[6] = '{0, 0, 1, 8'h81, 0, 0, 1, 8'h81};
      tbl[7] = '{1, 0, 0, 8'h7E, 1, 0, 0, 8'h7E};
      mreset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      for (int a = 0; a < 8; a++) begin
         rd_reg(3'(a), v);
         chk($sformatf("reset_reg%0d", a), v, 8'h00);
      end
      for (int i = 0; i < 8; i++) begin
         m_stb = tbl[i].stb; s_ack = tbl[i].ack; s_stall = tbl[i].stall; s_dat = tbl[i].d;
         tick();
         chk($sformatf("vec%0d_stb", i), s_sstb, tbl[i].e_stb);
         chk($sformatf("vec%0d_ack", i), s_mack, tbl[i].e_ack);
         chk($sformatf("vec%0d_dat", i), s_mdat, tbl[i].e_d);
      end
      m_stb = 0; s_ack = 0; s_stall = 0; tick();

      access(32'h1000, 0, 3, 8'h5A, -1, 0, 0, ac, na, d, ic, il);
      chk("normal_ack_cyc", ac, 3); chk("normal_nack", na, 1); chk("normal_dat", d, 8'h5A);
      access(32'h2000, 0, TO - 1, 8'hC3, -1, 0, 0, ac, na, d, ic, il);
      chk("edge7_ack_cyc", ac, TO - 1); chk("edge7_dat", d, 8'hC3);
      rd_reg(0, v); chk("edge7_status", v, 8'h00);
      access(32'h4000_0000, 0, TO, 8'h11, -1, 0, 0, ac, na, d, ic, il);
      chk("abort_ack_cyc", ac, TO); chk("abort_nack", na, 1); chk("abort_dat", d, 8'hFF);
      rd_reg(0, v); chk("fault1_status", v, 8'h01);
      rd_reg(1, v); chk("faddr_b0", v, 8'h00);
      rd_reg(4, v); chk("faddr_b3", v, 8'h40);
      rd_reg(5, v); chk("fcnt1", v, 8'd1);
      access(32'h5000_0000, 1, -1, 8'h00, -1, 0, 0, ac, na, d, ic, il);
      chk("fault2_ack_cyc", ac, TO);
      rd_reg(0, v); chk("fault2_status", v, 8'h81);
      rd_reg(4, v); chk("fault2_faddr_b3", v, 8'h40);
      rd_reg(5, v); chk("fcnt2", v, 8'd2);
      wr_reg(0, 8'h81);
      rd_reg(0, v); chk("w1c_status", v, 8'h00);
      wr_reg(6, 8'h01);
      rd_reg(6, v); chk("ien_read", v, 8'h01);
      access(32'h4400_0000, 0, -1, 8'h00, -1, 0, 0, ac, na, d, ic, il);
      chk("irq_rise_cyc", ic, TO + 2);
      access(32'h6000_0000, 1, -1, 8'h00, TO, 0, 8'h01, ac, na, d, ic, il);
      chk("collide_irq_low", il, 0);
      rd_reg(0, v); chk("collide_status", v, 8'h03);
      rd_reg(4, v); chk("collide_faddr_b3", v, 8'h60);
      access(32'h6400_0000, 0, -1, 8'h00, TO, 5, 8'h00, ac, na, d, ic, il);
      rd_reg(5, v); chk("fcnt_collide", v, 8'd1);
      wr_reg(7, 8'hFF);
      rd_reg(7, v); chk("reg7_read", v, 8'h00);

      m_adr = 32'h7000_0000; m_we = 0; m_stb = 1;
      repeat (5) tick();
      rst_n = 0; hi = 0; ak = 0;
      repeat (12) begin
         tick();
         if (s_sstb) hi++;
         if (s_mack) ak++;
      end
      chk("rst_sstb_track", hi, 12); chk("rst_no_abort", ak, 0);
      m_stb = 0; tick();
      rst_n = 1; tick();
      chk("rst_irq", s_irq, 1'b0);
      for (int a = 0; a < 8; a++) begin
         rd_reg(3'(a), v);
         chk($sformatf("rst_reg%0d", a), v, 8'h00);
      end

      for (int i = 0; i < 1500; i++) begin
         if (!m_stb && $urandom_range(0, 2) == 0) begin
            m_stb = 1; m_adr = $urandom; m_we = 1'($urandom_range(0, 1));
         end
         s_ack = m_stb && ($urandom_range(0, 9) == 0);
         s_dat = 8'($urandom); s_stall = 1'($urandom_range(0, 1));
         stb = ($urandom_range(0, 2) == 0); we = 1'($urandom_range(0, 1));
         adr = 3'($urandom_range(0, 7)); dat = 8'($urandom);
         tick();
         if (e_mack_g) m_stb = 0;
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
